// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clock divider bank.
package clk_div_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_t;

    localparam int CLK_DIV_CNT_W   = 24;
    localparam int CLK_DIV_DEF_DIV = 5000000;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, shadow divisor/mode, pending update and output logic.
// Optional sync_in restart is present only when CLK_DIV_SYNC_EN is defined.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CLK_DIV_CNT_W,
    parameter int DEF_DIV = CLK_DIV_DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync_in,
`endif
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  mode_t            wr_mode,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_div;
    logic [CNT_W-1:0] shd_div;
    logic [CNT_W-1:0] last;
    mode_t            act_mode;
    mode_t            shd_mode;
    logic             tc;
    logic             apply;
    logic             restart;

`ifdef CLK_DIV_SYNC_EN
    assign restart = sync_in;
`else
    assign restart = 1'b0;
`endif

    // A zero divisor is treated as one, so the channel then wraps every cycle.
    assign last  = (act_div == '0) ? '0 : act_div - CNT_W'(1);
    assign tc    = en && (cnt == last);
    assign apply = pending && (tc || !en || restart);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            act_div  <= DEF_VAL;
            shd_div  <= DEF_VAL;
            act_mode <= MODE_TOGGLE;
            shd_mode <= MODE_TOGGLE;
            pending  <= 1'b0;
        end else begin
            tick <= tc && !restart;

            if (restart || tc || apply) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (restart || (apply && (shd_mode != act_mode))) begin
                clk_out <= 1'b0;
            end else if (act_mode == MODE_PULSE) begin
                clk_out <= tc;
            end else if (tc) begin
                clk_out <= ~clk_out;
            end

            // apply needs pending=1, which blocks new writes, so the two never overlap.
            if (apply) begin
                act_div  <= shd_div;
                act_mode <= shd_mode;
                pending  <= 1'b0;
            end else if (wr) begin
                shd_div  <= wr_div;
                shd_mode <= wr_mode;
                pending  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent clock dividers with a valid/ready configuration port.
// Define CLK_DIV_SYNC_EN to add the sync_in input that restarts all channels together.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = CLK_DIV_CNT_W,
    parameter int DEF_DIV = CLK_DIV_DEF_DIV
) (
    input  logic                                          clk,
    input  logic                                          rst,
`ifdef CLK_DIV_SYNC_EN
    input  logic                                          sync_in,
`endif
    input  logic [NUM_CH-1:0]                             en,
    input  logic                                          cfg_valid,
    output logic                                          cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                              cfg_div,
    input  logic                                          cfg_mode,
    output logic [NUM_CH-1:0]                             clk_out,
    output logic [NUM_CH-1:0]                             tick
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr;

    // Out-of-range channel numbers match nothing: accepted, then dropped.
    always_comb begin
        cfg_ready = 1'b1;
        wr        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(cfg_ch) == i) begin
                cfg_ready = ~pending[i];
                wr[i]     = cfg_valid & ~pending[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
`ifdef CLK_DIV_SYNC_EN
            .sync_in (sync_in),
`endif
            .en      (en[g]),
            .wr      (wr[g]),
            .wr_div  (cfg_div),
            .wr_mode (mode_t'(cfg_mode)),
            .pending (pending[g]),
            .clk_out (clk_out[g]),
            .tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: a cycle-level reference model queues the expected outputs, a negedge monitor compares.
module tb_clk_div_bank;
    import clk_div_pkg::*;

    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sync_in = 1'b0;
    logic [NUM_CH-1:0] en = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [0:0]        cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_div = '0;
    logic              cfg_mode = 1'b0;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    always #5 clk = ~clk;

    clk_div_bank #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CLK_DIV_SYNC_EN
        .sync_in   (sync_in),
`endif
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    typedef struct packed {
        logic [NUM_CH-1:0] out;
        logic [NUM_CH-1:0] tck;
        logic              rdy;
        int                cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Reference model: per-channel position in period, divisor, mode, shadow and pending.
    int m_cnt[NUM_CH];
    int m_div[NUM_CH];
    int m_sdiv[NUM_CH];
    bit m_mode[NUM_CH];
    bit m_smode[NUM_CH];
    bit m_pend[NUM_CH];
    bit m_out[NUM_CH];
    bit m_tick[NUM_CH];

    function automatic void model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_cnt[ch] = 0;  m_div[ch] = DEF_DIV; m_sdiv[ch] = DEF_DIV;
            m_mode[ch] = 0; m_smode[ch] = 0;     m_pend[ch] = 0;
            m_out[ch] = 0;  m_tick[ch] = 0;
        end
    endfunction

    function automatic bit model_ready();
        if (int'(cfg_ch) >= NUM_CH) return 1'b1;
        return !m_pend[cfg_ch];
    endfunction

    function automatic void model_step();
        bit xfer;
        xfer = cfg_valid && model_ready();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            int d;
            bit tc;
            bit ap;
            d  = (m_div[ch] == 0) ? 1 : m_div[ch];
            tc = en[ch] && (m_cnt[ch] == d - 1);
            ap = m_pend[ch] && (tc || !en[ch] || sync_in);
            m_tick[ch] = tc && !sync_in;
            if (sync_in || (ap && m_smode[ch] != m_mode[ch])) m_out[ch] = 0;
            else if (m_mode[ch])                            m_out[ch] = tc;
            else if (tc)                                    m_out[ch] = !m_out[ch];
            if (sync_in || tc || ap) m_cnt[ch] = 0;
            else if (en[ch])         m_cnt[ch] = m_cnt[ch] + 1;
            if (ap) begin
                m_div[ch] = m_sdiv[ch]; m_mode[ch] = m_smode[ch]; m_pend[ch] = 0;
            end
            if (xfer && int'(cfg_ch) == ch) begin
                m_sdiv[ch] = int'(cfg_div); m_smode[ch] = cfg_mode; m_pend[ch] = 1;
            end
        end
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, expv, cyc, $time);
        end
    endtask

    // Called at posedge+1 with inputs already set: queue this cycle's expected outputs, advance the model, wait one clock.
    task automatic cycle();
        exp_t e;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            e.out[ch] = m_out[ch];
            e.tck[ch] = m_tick[ch];
        end
        e.rdy = model_ready();
        e.cyc = cyc;
        exp_q.push_back(e);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("clk_out",   8'(clk_out),   8'(e.out));
                check("tick",      8'(tick),      8'(e.tck));
                check("cfg_ready", 8'(cfg_ready), 8'(e.rdy));
            end
        end
    end

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        model_reset();
        #2;
        check("reset_clk_out",   8'(clk_out),   8'h0);
        check("reset_tick",      8'(tick),      8'h0);
        check("reset_cfg_ready", 8'(cfg_ready), 8'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Default divisor on both channels
        en = 2'b11;
        repeat (20) cycle();

        // ch0 -> div 3, pulse mode, issued mid-period
        cfg_valid = 1; cfg_ch = 0; cfg_div = 8'd3; cfg_mode = 1;
        cycle();
        cfg_valid = 0;
        repeat (20) cycle();

        // ch1 -> div 0 in toggle mode
        cfg_valid = 1; cfg_ch = 1; cfg_div = 8'd0; cfg_mode = 0;
        cycle();
        cfg_valid = 0;
        repeat (12) cycle();

        // Hold ch0 at cnt=2, update it while disabled
        cfg_ch = 0;
        for (int k = 0; k < 40 && m_cnt[0] != 2; k++) cycle();
        en[0] = 1'b0;
        cycle(); cycle();
        cfg_valid = 1; cfg_div = 8'd5; cfg_mode = 0;
        cycle();
        cfg_valid = 0;
        cycle(); cycle();
        en[0] = 1'b1;
        repeat (20) cycle();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            en        = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
            cfg_valid = ($urandom_range(0, 4) == 0);
            cfg_ch    = 1'($urandom);
            cfg_div   = 8'($urandom_range(0, 9));
            cfg_mode  = 1'($urandom);
`ifdef CLK_DIV_SYNC_EN
            sync_in   = ($urandom_range(0, 24) == 0);
`endif
            cycle();
        end
        sync_in = 0; cfg_valid = 0; en = 2'b11;

`ifdef CLK_DIV_SYNC_EN
        // Equal divisors, then sync pulses at arbitrary phases
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cfg_ch = 1'(ch); cfg_div = 8'd3; cfg_mode = 0;
            for (int k = 0; k < 20 && !model_ready(); k++) cycle();
            cfg_valid = 1; cycle(); cfg_valid = 0;
            repeat (12) cycle();
        end
        for (int p = 0; p < 4; p++) begin
            repeat ($urandom_range(1, 7)) cycle();
            sync_in = 1; cycle(); sync_in = 0;
            repeat (10) cycle();
        end
`endif

        // Leave an update pending on ch1, then reset between edges
        cfg_ch = 1; cfg_div = 8'd9; cfg_mode = 0;
        for (int k = 0; k < 20 && !model_ready(); k++) cycle();
        cfg_valid = 1; cycle(); cfg_valid = 0;
        repeat (20) cycle();
        for (int k = 0; k < 20 && m_cnt[1] != 1; k++) cycle();
        cfg_valid = 1; cfg_div = 8'd2; cfg_mode = 1;
        cycle();
        cfg_valid = 0;
        cycle();
        #6;
        rst = 1'b1;
        #1;
        check("async_rst_clk_out",   8'(clk_out),   8'h0);
        check("async_rst_tick",      8'(tick),      8'h0);
        check("async_rst_cfg_ready", 8'(cfg_ready), 8'h1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (20) cycle();

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
